// File: rtl/mem_port_sequencer_if.sv
// rtl/mem_port_sequencer_if.sv - requester, read and memory-side signals of the memory port sequencer
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              clear_req;
    logic              busy;
    logic              w0_valid;
    logic              w0_ready;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              w1_valid;
    logic              w1_ready;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  clear_req, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data,
               rd_req, rd_addr, mem_rdata,
        output busy, w0_ready, w1_ready, rd_ready, rd_valid,
               mem_wen, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output clear_req, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data,
               rd_req, rd_addr, mem_rdata,
        input  busy, w0_ready, w1_ready, rd_ready, rd_valid,
               mem_wen, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - hardware clear, round-robin write arbitration and read tracking for a 1R1W register file
module mem_port_sequencer #(
    parameter int              ADDR_W         = 5,
    parameter int              DATA_W         = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_port_sequencer_if.slave  bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              rd_valid_q, rd_valid_d;

    logic              w0_ready, w1_ready, rd_ready, busy;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              grant1;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        w0_ready     = 1'b0;
        w1_ready     = 1'b0;
        rd_ready     = 1'b0;
        busy         = 1'b0;
        mem_wen      = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        // On contention the requester that did not win last time is served.
        grant1       = (bus.w0_valid && bus.w1_valid) ? !last_grant_q : bus.w1_valid;

        if (state_q == ST_CLEAR) begin
            busy      = 1'b1;
            mem_wen   = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = INIT_VALUE;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end else if (bus.clear_req) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end else begin
            rd_ready = bus.rd_req;
            if (bus.w0_valid || bus.w1_valid) begin
                mem_wen      = 1'b1;
                last_grant_d = grant1;
                if (grant1) begin
                    w1_ready  = 1'b1;
                    mem_waddr = bus.w1_addr;
                    mem_wdata = bus.w1_data;
                end else begin
                    w0_ready  = 1'b1;
                    mem_waddr = bus.w0_addr;
                    mem_wdata = bus.w0_data;
                end
            end
        end

        if (!resetn) begin
            w0_ready = 1'b0;
            w1_ready = 1'b0;
            rd_ready = 1'b0;
            mem_wen  = 1'b0;
        end
        rd_valid_d = bus.rd_req && rd_ready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.w0_ready  = w0_ready;
    assign bus.w1_ready  = w1_ready;
    assign bus.rd_ready  = rd_ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.mem_wen   = mem_wen;
    assign bus.mem_waddr = mem_waddr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_raddr = bus.rd_addr;
endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - directed self-checking bench for mem_port_sequencer
module tb_mem_port_sequencer;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus ();
    mem_port_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();

    mem_port_sequencer #(
        .ADDR_W(5), .DATA_W(32), .INIT_VALUE(32'hDEADBEEF), .CLEAR_ON_RESET(1'b1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .bus(bus.slave)
    );

    mem_port_sequencer #(
        .ADDR_W(5), .DATA_W(32), .INIT_VALUE(32'h0), .CLEAR_ON_RESET(1'b0)
    ) u_dut_nc (
        .clk(clk), .resetn(resetn), .bus(bus0.slave)
    );

    // 32x32 register file: registered read of the pre-write contents
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        #1;
        chk({tag, "_rd_ready"}, bus.rd_ready, 1);
        chk({tag, "_raddr"}, bus.mem_raddr, a);
        cyc();
        bus.rd_req = 1'b0;
        chk({tag, "_rd_valid"}, bus.rd_valid, 1);
        chk(tag, bus.mem_rdata, exp);
    endtask

    initial begin
        resetn = 1'b0;
        bus.clear_req = 0; bus.w0_valid = 0; bus.w0_addr = 0; bus.w0_data = 0;
        bus.w1_valid = 1; bus.w1_addr = 5'd7; bus.w1_data = 32'h77;
        bus.rd_req = 1; bus.rd_addr = 0;
        bus0.clear_req = 0; bus0.w0_valid = 1; bus0.w0_addr = 5'd2; bus0.w0_data = 32'h22;
        bus0.w1_valid = 0; bus0.w1_addr = 0; bus0.w1_data = 0;
        bus0.rd_req = 0; bus0.rd_addr = 0; bus0.mem_rdata = 0;

        // reset state
        cyc(); cyc();
        chk("rst_mem_wen", bus.mem_wen, 0);
        chk("rst_w1_ready", bus.w1_ready, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_nc_w0_ready", bus0.w0_ready, 0);
        chk("rst_nc_busy", bus0.busy, 0);

        // test 1: clear after reset release, 32 busy cycles
        resetn = 1'b1;
        bus.rd_req = 1'b0;
        #1;
        chk("nc_first_grant", bus0.w0_ready, 1);
        chk("nc_first_waddr", bus0.mem_waddr, 2);
        for (int k = 0; k < 32; k++) begin
            chk("clr_busy", bus.busy, 1);
            chk("clr_wen", bus.mem_wen, 1);
            chk("clr_waddr", bus.mem_waddr, k);
            chk("clr_wdata", bus.mem_wdata, 32'hDEADBEEF);
            chk("clr_w1_ready", bus.w1_ready, 0);
            chk("nc_busy", bus0.busy, 0);
            cyc();
            bus0.w0_valid = 1'b0;
        end
        chk("clr_done_busy", bus.busy, 0);
        chk("run1_w1_ready", bus.w1_ready, 1);
        chk("run1_waddr", bus.mem_waddr, 7);
        chk("run1_wdata", bus.mem_wdata, 32'h77);
        cyc();
        bus.w1_valid = 1'b0;
        do_read(5'd0, 32'hDEADBEEF, "rd0");
        do_read(5'd17, 32'hDEADBEEF, "rd17");
        do_read(5'd31, 32'hDEADBEEF, "rd31");
        do_read(5'd7, 32'h77, "rd7");

        // test 2: both valid every cycle, alternating grants from requester 0
        bus.w0_valid = 1; bus.w0_addr = 5'd3;
        bus.w1_valid = 1; bus.w1_addr = 5'd4;
        for (int n = 0; n < 4; n++) begin
            bus.w0_data = 32'hA0 + n;
            bus.w1_data = 32'hB0 + n;
            #1;
            chk("rr_w0_ready", bus.w0_ready, (n % 2 == 0) ? 1 : 0);
            chk("rr_w1_ready", bus.w1_ready, (n % 2 == 0) ? 0 : 1);
            chk("rr_waddr", bus.mem_waddr, (n % 2 == 0) ? 3 : 4);
            chk("rr_wdata", bus.mem_wdata, (n % 2 == 0) ? 32'hA0 + n : 32'hB0 + n);
            cyc();
        end
        bus.w0_valid = 0; bus.w1_valid = 0;
        do_read(5'd3, 32'hA2, "rr_rd3");
        do_read(5'd4, 32'hB3, "rr_rd4");

        // test 3: only w1 three times, then contention goes to w0
        bus.w1_valid = 1;
        for (int n = 0; n < 3; n++) begin
            bus.w1_data = 32'hC0 + n;
            #1;
            chk("solo_w1_ready", bus.w1_ready, 1);
            chk("solo_w0_ready", bus.w0_ready, 0);
            cyc();
        end
        bus.w0_valid = 1; bus.w0_data = 32'hD0;
        #1;
        chk("cont_w0_ready", bus.w0_ready, 1);
        chk("cont_w1_ready", bus.w1_ready, 0);
        cyc();
        bus.w0_valid = 0; bus.w1_valid = 0;
        do_read(5'd3, 32'hD0, "solo_rd3");
        do_read(5'd4, 32'hC2, "solo_rd4");

        // test 4: same-address read and write
        bus.w0_valid = 1; bus.w0_addr = 5'd5; bus.w0_data = 32'h1234;
        bus.rd_req = 1; bus.rd_addr = 5'd5;
        #1;
        chk("rbw_w0_ready", bus.w0_ready, 1);
        chk("rbw_rd_ready", bus.rd_ready, 1);
        cyc();
        bus.w0_valid = 0; bus.rd_req = 0;
        chk("rbw_rd_valid", bus.rd_valid, 1);
        chk("rbw_old", bus.mem_rdata, 32'hDEADBEEF);
        do_read(5'd5, 32'h1234, "rbw_new");

        // test 5: clear_req with w0 held, second clear_req mid-clear ignored
        bus.w0_valid = 1; bus.w0_addr = 5'd9; bus.w0_data = 32'h99;
        bus.rd_req = 1; bus.rd_addr = 5'd0;
        bus.clear_req = 1;
        #1;
        chk("creq_w0_ready", bus.w0_ready, 0);
        chk("creq_wen", bus.mem_wen, 0);
        chk("creq_rd_ready", bus.rd_ready, 0);
        chk("creq_busy", bus.busy, 0);
        cyc();
        bus.clear_req = 0; bus.rd_req = 0;
        chk("creq_rd_valid", bus.rd_valid, 0);
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                bus.clear_req = 1;
                #1;
            end
            chk("clr2_busy", bus.busy, 1);
            chk("clr2_w0_ready", bus.w0_ready, 0);
            chk("clr2_waddr", bus.mem_waddr, k);
            cyc();
            bus.clear_req = 0;
        end
        chk("clr2_done_busy", bus.busy, 0);
        chk("clr2_w0_grant", bus.w0_ready, 1);
        chk("clr2_waddr_run", bus.mem_waddr, 9);
        chk("clr2_wdata_run", bus.mem_wdata, 32'h99);
        cyc();
        bus.w0_valid = 0;
        do_read(5'd9, 32'h99, "clr2_rd9");
        do_read(5'd3, 32'hDEADBEEF, "clr2_rd3");

        // test 6: reset at clr_cnt=10 restarts the clear
        bus.clear_req = 1;
        #1;
        cyc();
        bus.clear_req = 0;
        repeat (10) cyc();
        chk("mid_waddr", bus.mem_waddr, 10);
        chk("mid_busy", bus.busy, 1);
        bus0.w0_valid = 1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_wen", bus.mem_wen, 0);
        chk("mid_rst_nc_ready", bus0.w0_ready, 0);
        cyc();
        chk("mid_rst_wen2", bus.mem_wen, 0);
        cyc();
        chk("mid_rst_wen3", bus.mem_wen, 0);
        resetn = 1'b1;
        #1;
        chk("nc_rel_grant", bus0.w0_ready, 1);
        chk("nc_rel_busy", bus0.busy, 0);
        for (int k = 0; k < 32; k++) begin
            chk("rclr_busy", bus.busy, 1);
            chk("rclr_wen", bus.mem_wen, 1);
            chk("rclr_waddr", bus.mem_waddr, k);
            chk("rclr_nc_busy", bus0.busy, 0);
            cyc();
            bus0.w0_valid = 0;
        end
        chk("rclr_done_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
